// File: rtl/cpu_pkg.sv
// Types and constants shared by fetch, instruction memory and decode.
package cpu_pkg;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 19;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter: async active-low reset, load for jumps, increment with wrap, hold.
module pc_counter #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC drive, IF/ID capture register, decode handshake,
// jump redirect and delivered-instruction counter.
module fetch_unit #(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  mem_address,
  input  logic [INSTR_W-1:0] mem_instruction,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instruction,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [15:0]        fetch_count
);
  import cpu_pkg::*;

  fetch_state_t state, state_next;
  logic [ADDR_W-1:0] pc;
  logic deliver;
  logic capture;
  logic valid_next;

  assign deliver     = out_valid && out_ready;
  assign mem_address = pc;

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .load   (redirect_valid),
    .target (redirect_target),
    .inc    (capture),
    .pc     (pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Redirect beats everything; BOOT spends one cycle without capturing.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    valid_next = out_valid;
    if (redirect_valid) begin
      state_next = RUN;
      valid_next = 1'b0;
    end else if (state == BOOT) begin
      state_next = RUN;
    end else if (fetch_en) begin
      if (!out_valid || out_ready) begin
        capture    = 1'b1;
        valid_next = 1'b1;
        state_next = RUN;
      end else begin
        state_next = HOLD;
      end
    end else if (deliver) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid       <= 1'b0;
      out_instruction <= '0;
      out_pc          <= '0;
      fetch_count     <= '0;
    end else begin
      out_valid <= valid_next;
      if (capture) begin
        out_instruction <= mem_instruction;
        out_pc          <= pc;
      end
      if (deliver) begin
        fetch_count <= fetch_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, checked
// against a transaction-level model of the fetch rules.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [11:0] mem_address;
  logic [18:0] mem_instruction;
  logic        redirect_valid;
  logic [11:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_instruction;
  logic [11:0] out_pc;
  logic [15:0] fetch_count;

  logic [18:0] mem [4096];

  int tests = 0;
  int fails = 0;

  // Reference state: what decode should be seeing.
  bit          m_boot;
  int          m_pc;
  bit          m_valid;
  logic [18:0] m_instr;
  int          m_opc;
  int          m_cnt;

  always #5 clk = ~clk;

  assign mem_instruction = mem[mem_address];

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_en        (fetch_en),
    .mem_address     (mem_address),
    .mem_instruction (mem_instruction),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .fetch_count     (fetch_count)
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_pc = 0; m_valid = 0; m_instr = '0; m_opc = 0; m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},  int'(mem_address), m_pc);
    check({tag, ".valid"}, int'(out_valid), int'(m_valid));
    check({tag, ".pc"},    int'(out_pc), m_opc);
    check({tag, ".instr"}, int'(out_instruction), int'(m_instr));
    check({tag, ".count"}, int'(fetch_count), m_cnt);
  endtask

  // One clock: apply inputs, advance the model by the fetch rules, compare.
  task automatic step(input bit en, input bit rdy, input bit redir, input int tgt,
                      input string tag);
    bit deliver;
    fetch_en        = en;
    out_ready       = rdy;
    redirect_valid  = redir;
    redirect_target = 12'(tgt);
    deliver = m_valid && rdy;
    @(posedge clk);
    if (deliver) m_cnt = (m_cnt + 1) % 65536;
    if (redir) begin
      m_pc = tgt; m_valid = 0; m_boot = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (en) begin
      if (!m_valid || rdy) begin
        m_instr = mem[m_pc]; m_opc = m_pc; m_valid = 1; m_pc = (m_pc + 1) % 4096;
      end
    end else if (deliver) begin
      m_valid = 0;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    int guard;
    for (int a = 0; a < 4096; a++) mem[a] = 19'(a);
    rst = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;

    // BOOT edge then streaming from address 0
    step(1, 1, 0, 0, "boot");
    check("boot_no_valid", int'(out_valid), 0);
    step(1, 1, 0, 0, "first");
    check("first_pc", int'(out_pc), 0);
    check("first_valid", int'(out_valid), 1);
    guard = 0;
    while (m_opc != 5 && guard < 50) begin
      step(1, 1, 0, 0, "stream");
      guard++;
    end
    check("stream_bound", guard, 5);
    check("count5", int'(fetch_count), 5);

    // Stall decode for three cycles
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, "stall");
      check("stall_pc", int'(out_pc), 5);
      check("stall_instr", int'(out_instruction), 5);
      check("stall_addr", int'(mem_address), 6);
    end
    step(1, 1, 0, 0, "resume");
    check("resume_pc", int'(out_pc), 6);

    // Redirect to 15 when PC reaches 11; instruction 10 delivered same cycle
    while (m_pc != 11 && guard < 100) begin
      step(1, 1, 0, 0, "to11");
      guard++;
    end
    check("pre_redir_pc", int'(out_pc), 10);
    step(1, 1, 1, 15, "redir");
    check("redir_bubble", int'(out_valid), 0);
    check("redir_count", int'(fetch_count), 11);
    step(1, 1, 0, 0, "redir_t0");
    check("redir_t0_pc", int'(out_pc), 15);
    step(1, 1, 0, 0, "redir_t1");
    check("redir_t1_pc", int'(out_pc), 16);

    // Wrap at the top of memory
    step(1, 1, 1, 4094, "wrap_jmp");
    step(1, 1, 0, 0, "wrap_a");
    check("wrap_a_pc", int'(out_pc), 4094);
    step(1, 1, 0, 0, "wrap_b");
    check("wrap_b_pc", int'(out_pc), 4095);
    step(1, 1, 0, 0, "wrap_c");
    check("wrap_c_pc", int'(out_pc), 0);
    check("wrap_c_valid", int'(out_valid), 1);

    // Fetch disabled with a redirect in the middle
    step(0, 1, 0, 0, "dis0");
    step(0, 1, 1, 100, "dis1");
    check("dis_addr", int'(mem_address), 100);
    step(0, 1, 0, 0, "dis2");
    step(0, 1, 0, 0, "dis3");
    check("dis_hold_valid", int'(out_valid), 0);
    step(1, 1, 0, 0, "en_back");
    check("en_back_pc", int'(out_pc), 100);

    // Reset while decode is stalled
    step(1, 0, 0, 0, "hold0");
    step(1, 0, 0, 0, "hold1");
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("midreset");
    check("midreset_count", int'(fetch_count), 0);
    @(posedge clk); #2;
    rst = 1'b1;
    step(1, 1, 0, 0, "reboot");
    check("reboot_valid", int'(out_valid), 0);
    step(1, 1, 0, 0, "reboot_first");
    check("reboot_pc", int'(out_pc), 0);

    // Random traffic over random memory contents
    for (int a = 0; a < 4096; a++) mem[a] = 19'($urandom);
    mem[7] = '0;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 15) == 0), int'($urandom_range(0, 4095)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
